sa_output_collector: RTL
========================

# sa_output_collector

Receives the three skewed result lanes coming out of the systolic array (SA) and removes the 0/1/2-cycle lane skew that the SA input feeder applies. It sums the aligned lanes into one saturated 16-bit output pixel and stores a full SIZE×SIZE result matrix in raster order. It then drains that matrix serially to the downstream consumer with a valid/ready handshake. It sits between the SA outputs and the next layer / result buffer.

## Interface
- SIZE, default 5: output matrix dimension (= padded input dimension − 2 for 3×3 kernels); pixel count N = SIZE*SIZE, max 255×255 supported by counters.
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- srt_sig  input  1  lane-1 valid from SA; lane 2 valid is srt_sig delayed 1 cycle, lane 3 delayed 2.
- in1  input  signed 16  kernel-row-0 partial sum, valid with srt_sig in cycle t.
- in2  input  signed 16  kernel-row-1 partial sum for the same pixel, cycle t+1.
- in3  input  signed 16  kernel-row-2 partial sum for the same pixel, cycle t+2.
- out_ready  input  1  downstream accepts out this cycle.
- out  output  signed 16  current drained pixel.
- out_valid  output  1  out holds a valid pixel.
- done  output  1  one-cycle pulse after last pixel accepted.
- ovf  output  1  sticky: an aligned pixel arrived while draining and was dropped.

## Operation
- Deskew: in1 through 2 register stages, in2 through 1, in3 used directly; srt_sig through 2 stages gives aligned valid v_al. Delay registers run every cycle, regardless of state.
- Sum: sign-extend three lanes to 18 bits, add. Saturate to [−32768, 32767] when writing.
- Memory: N × signed 16. Registers: wr_idx (16 bit), rd_idx (16 bit), state.
- States:
  - COLLECT (reset state):
    - On v_al: mem[wr_idx] ← saturated sum, wr_idx+1.
    - Write with wr_idx = N−1 → wr_idx ← 0, state → DRAIN.
  - DRAIN:
    - out_valid = 1; out = mem[rd_idx] (combinational read).
    - On out_valid && out_ready: rd_idx+1.
    - Transfer at rd_idx = N−1 → rd_idx ← 0, done ← 1 next cycle, state → COLLECT.
    - Any v_al in DRAIN: pixel dropped, ovf ← 1 (held until reset), wr_idx unchanged.
- out_ready is ignored outside DRAIN; out_valid is 0 in COLLECT, with out = 0.
- Gaps in srt_sig are allowed. Pixels are counted only on v_al, so bubbles never corrupt order.

## Timing
- Reset values: out = 0, out_valid = 0, done = 0, ovf = 0, state = COLLECT, wr_idx = rd_idx = 0, all delay registers and delayed valids = 0. mem contents are not reset.
- Reset mid-operation:
  - Everything above returns to its reset value immediately.
  - Any partially collected matrix is discarded.
  - Lane data in flight in the delay stages is lost.
- Pixel whose srt_sig is high in cycle t: written at the rising edge ending cycle t+2.
- Last pixel (lane 1 at cycle t): state = DRAIN and out_valid = 1 from cycle t+3.
- Drain throughput: 1 pixel/cycle while out_ready is held high. N-pixel drain takes N cycles with ready high.
- done: high exactly the cycle after the final transfer, together with out_valid = 0.
- Back-to-back matrices: a new srt_sig may be asserted in the cycle done is high. An earlier srt_sig whose v_al lands inside DRAIN sets ovf.
- out is stable while out_valid && !out_ready: rd_idx does not advance.

## Test plan
- Basic, SIZE = 2:
  - Stimulus: 4 consecutive srt_sig pulses; in1 = 1,2,3,4 at t..t+3, in2 = 10,20,30,40 at t+1..t+4, in3 = 100,200,300,400 at t+2..t+5; out_ready = 1.
  - Required: out_valid rises at t+6; out = 111,222,333,444 on consecutive cycles; done pulses at t+10.
- Saturation: in1 = in2 = in3 = 20000 → stored pixel 32767; in1 = in2 = in3 = −20000 → −32768; mixed 30000, 30000, −30000 → 30000 (no clip).
- Bubbles: SIZE = 2, srt_sig pattern 1,0,0,1,1,0,1 with matching skewed lanes → exactly 4 pixels in correct order; DRAIN entered 3 cycles after the 4th pulse.
- Backpressure: during drain, toggle out_ready 1,0,0,1,… → out holds value while ready = 0; each pixel appears exactly once; done follows only the Nth accepted transfer.
- Overrun: assert srt_sig 2 cycles after entering DRAIN with out_ready = 0 → ovf = 1 and stays 1; drained data unchanged; next matrix collects normally from wr_idx 0.
- Async reset: assert rst_n = 0 mid-COLLECT (after 2 of 4 pixels) and mid-DRAIN → outputs and state return to reset values immediately; a subsequent full matrix drains correctly in order.

Source files
------------

// File: rtl/sa_output_collector.sv
// Deskews the three SA result lanes, sums them with saturation into a SIZE x SIZE matrix, then drains it serially.
// Latency: a pixel whose srt_sig is high in cycle t is stored at the end of cycle t+2; after the last pixel, out_valid rises in cycle t+3.
// Backpressure: during drain, out and rd_idx hold while out_ready is low; aligned pixels arriving mid-drain are dropped and set sticky ovf.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   srt_sig            lane-1 valid (lanes 2/3 follow one and two cycles later)
//   in1, in2, in3      signed 16-bit partial sums for kernel rows 0/1/2
//   out_ready          downstream accepts out this cycle
//   out, out_valid     drained pixel and its valid
//   done               one-cycle pulse after the final pixel is accepted
//   ovf                sticky flag: an aligned pixel was dropped during drain
module sa_output_collector #(
    parameter int SIZE = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               srt_sig,
    input  logic signed [15:0] in1,
    input  logic signed [15:0] in2,
    input  logic signed [15:0] in3,
    input  logic               out_ready,
    output logic signed [15:0] out,
    output logic               out_valid,
    output logic               done,
    output logic               ovf
);

    localparam int N  = SIZE * SIZE;
    localparam int AW = (N > 1) ? $clog2(N) : 1;
    localparam logic [15:0] LAST = 16'(N - 1);

    localparam logic STATE_COLLECT = 1'b0;
    localparam logic STATE_DRAIN   = 1'b1;

    logic signed [15:0] in1_d1_q, in1_d2_q, in2_d1_q;
    logic               srt_d1_q, srt_d2_q;
    logic               state_q, state_d;
    logic [15:0]        wr_idx_q, wr_idx_d;
    logic [15:0]        rd_idx_q, rd_idx_d;
    logic               done_q, done_d;
    logic               ovf_q, ovf_d;
    logic               wr_en;

    logic signed [15:0] mem [N];

    logic               v_al;
    logic signed [17:0] sum_w;
    logic signed [15:0] sat_w;

    // srt_sig delayed twice lines up with in1(t), in2(t+1), in3(t+2).
    assign v_al = srt_d2_q;

    assign sum_w = $signed({{2{in1_d2_q[15]}}, in1_d2_q})
                 + $signed({{2{in2_d1_q[15]}}, in2_d1_q})
                 + $signed({{2{in3[15]}}, in3});

    always_comb begin
        if (sum_w > 18'sd32767) begin
            sat_w = 16'sh7FFF;
        end else if (sum_w < -18'sd32768) begin
            sat_w = 16'sh8000;
        end else begin
            sat_w = sum_w[15:0];
        end
    end

    always_comb begin
        state_d  = state_q;
        wr_idx_d = wr_idx_q;
        rd_idx_d = rd_idx_q;
        done_d   = 1'b0;
        ovf_d    = ovf_q;
        wr_en    = 1'b0;
        if (state_q == STATE_COLLECT) begin
            if (v_al) begin
                wr_en = 1'b1;
                if (wr_idx_q == LAST) begin
                    wr_idx_d = 16'd0;
                    state_d  = STATE_DRAIN;
                end else begin
                    wr_idx_d = wr_idx_q + 16'd1;
                end
            end
        end else begin
            // No room to buffer a second matrix, so anything aligned now is lost.
            if (v_al) begin
                ovf_d = 1'b1;
            end
            if (out_ready) begin
                if (rd_idx_q == LAST) begin
                    rd_idx_d = 16'd0;
                    done_d   = 1'b1;
                    state_d  = STATE_COLLECT;
                end else begin
                    rd_idx_d = rd_idx_q + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in1_d1_q <= '0;
            in1_d2_q <= '0;
            in2_d1_q <= '0;
            srt_d1_q <= 1'b0;
            srt_d2_q <= 1'b0;
            state_q  <= STATE_COLLECT;
            wr_idx_q <= 16'd0;
            rd_idx_q <= 16'd0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            in1_d1_q <= in1;
            in1_d2_q <= in1_d1_q;
            in2_d1_q <= in2;
            srt_d1_q <= srt_sig;
            srt_d2_q <= srt_d1_q;
            state_q  <= state_d;
            wr_idx_q <= wr_idx_d;
            rd_idx_q <= rd_idx_d;
            done_q   <= done_d;
            ovf_q    <= ovf_d;
        end
    end

    // Pixel storage is deliberately not reset; wr_en is low while in reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx_q[AW-1:0]] <= sat_w;
        end
    end

    assign out_valid = (state_q == STATE_DRAIN);
    assign out       = out_valid ? mem[rd_idx_q[AW-1:0]] : 16'sd0;
    assign done      = done_q;
    assign ovf       = ovf_q;

endmodule
